// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// State encodings are plain constants so older tools and waveform viewers decode them consistently.
package if_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  typedef logic [1:0] fetch_state_e;
  localparam fetch_state_e IDLE  = 2'd0;
  localparam fetch_state_e WAIT  = 2'd1;
  localparam fetch_state_e DRAIN = 2'd2;

  // pc is kept at full 32 bits; narrower ADDR_W builds zero-extend into it
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue: DEPTH x fetch_entry_t, head visible combinationally, push/pop same cycle at any count.
// Synchronous flush empties it; a push into a full queue without a pop is dropped.
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS32 fetch stage: one outstanding imem read, DEPTH-entry prefetch queue, redirect flush; head valid 1 cycle after rvalid.
// Requests stop while queue+outstanding would exceed DEPTH; IF_PERF_CNT_EN adds push/redirect counters.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushes,
`endif
  output logic [ADDR_W-1:0]  fetch_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     state;
  fetch_state_e     state_n;
  logic [ADDR_W-1:0] pend_pc;
  logic [CNT_W-1:0] q_count;
  logic             q_empty;
  logic             q_full;
  logic             issue;
  logic             push;
  fetch_entry_t     push_data;
  fetch_entry_t     head;

  // IDLE means nothing outstanding, so the credit check reduces to one free slot
  assign imem_req  = !reset && (state == IDLE) && (q_count < CNT_W'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;
  assign push      = (state == WAIT) && imem_rvalid && !redirect_valid;

  assign push_data.pc    = 32'(pend_pc);
  assign push_data.instr = imem_rdata;

  assign instr_valid = !q_empty;
  assign instr       = head.instr;
  assign instr_pc    = ADDR_W'(head.pc);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (issue) state_n = redirect_valid ? DRAIN : WAIT;
      WAIT:    if (imem_rvalid) state_n = IDLE;
               else if (redirect_valid) state_n = DRAIN;
      // a redirect coinciding with the drained response has nothing left to wait for
      DRAIN:   if (imem_rvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
    end else begin
      state <= state_n;
      if (issue) pend_pc <= fetch_pc;
      if (redirect_valid) fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (issue)     fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
    end
  end

  if_prefetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (instr_ready),
    .head      (head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (push && (perf_fetched != '1))           perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid && (perf_flushes != '1)) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

  a_no_rvalid_idle: assert property (@(posedge clk) disable iff (reset) !(imem_rvalid && (state == IDLE)));
  a_no_full_push:   assert property (@(posedge clk) disable iff (reset) !(push && q_full && !instr_ready));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table for streaming/backpressure,
// hand sequences for redirect, hold-without-grant and mid-transaction reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [31:0] fetch_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_grants = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
`ifdef IF_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes),
`endif
    .fetch_pc       (fetch_pc)
  );

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        ivld;
    logic [31:0] ins;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic g, logic rv, logic [31:0] rd, logic rdy,
                              logic rq, logic [31:0] ad, logic iv, logic [31:0] in, logic [31:0] ip);
    vec_t v;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
    v.req = rq; v.addr = ad; v.ivld = iv; v.ins = in; v.ipc = ip;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, leave time for outputs to settle.
  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                     input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy;
    redirect_valid = redir; redirect_pc = rpc;
    #1;
    if (imem_req && imem_gnt) n_grants++;
  endtask

  task automatic chk_out(input string nm, input logic rq, input logic [31:0] ad, input logic iv);
    chk({nm, ".req"}, 32'(imem_req), 32'(rq));
    chk({nm, ".addr"}, imem_addr, ad);
    chk({nm, ".ivld"}, 32'(instr_valid), 32'(iv));
  endtask

  task automatic chk_head(input string nm, input logic [31:0] in, input logic [31:0] ip);
    chk({nm, ".instr"}, instr, in);
    chk({nm, ".ipc"}, instr_pc, ip);
  endtask

  initial begin
    // gnt rv rdata ready | req addr ivld instr pc
    tbl[0]  = mk(1, 0, 32'h0,        0, 1, 32'h00, 0, 32'h0,        32'h0);
    tbl[1]  = mk(0, 1, 32'h20080005, 0, 0, 32'h04, 0, 32'h0,        32'h0);
    tbl[2]  = mk(1, 0, 32'h0,        0, 1, 32'h04, 1, 32'h20080005, 32'h0);
    tbl[3]  = mk(0, 1, 32'h2009000A, 0, 0, 32'h08, 1, 32'h20080005, 32'h0);
    tbl[4]  = mk(1, 0, 32'h0,        0, 1, 32'h08, 1, 32'h20080005, 32'h0);
    tbl[5]  = mk(0, 1, 32'h01095020, 0, 0, 32'h0C, 1, 32'h20080005, 32'h0);
    tbl[6]  = mk(1, 0, 32'h0,        0, 1, 32'h0C, 1, 32'h20080005, 32'h0);
    tbl[7]  = mk(0, 1, 32'h012A4020, 0, 0, 32'h10, 1, 32'h20080005, 32'h0);
    tbl[8]  = mk(1, 0, 32'h0,        0, 0, 32'h10, 1, 32'h20080005, 32'h0);
    tbl[9]  = mk(0, 0, 32'h0,        1, 0, 32'h10, 1, 32'h20080005, 32'h0);
    tbl[10] = mk(1, 0, 32'h0,        0, 1, 32'h10, 1, 32'h2009000A, 32'h4);
    tbl[11] = mk(0, 1, 32'h00000001, 0, 0, 32'h14, 1, 32'h2009000A, 32'h4);
    tbl[12] = mk(1, 0, 32'h0,        1, 0, 32'h14, 1, 32'h2009000A, 32'h4);
    tbl[13] = mk(0, 0, 32'h0,        1, 1, 32'h14, 1, 32'h01095020, 32'h8);
    tbl[14] = mk(0, 0, 32'h0,        1, 1, 32'h14, 1, 32'h012A4020, 32'hC);
    tbl[15] = mk(0, 0, 32'h0,        1, 1, 32'h14, 1, 32'h00000001, 32'h10);
    tbl[16] = mk(0, 0, 32'h0,        0, 1, 32'h14, 0, 32'h0,        32'h0);

    // reset held
    repeat (2) @(negedge clk);
    #1;
    chk_out("rst", 1'b0, 32'h0, 1'b0);
    chk_head("rst", 32'h0, 32'h0);
    chk("rst.fetch_pc", fetch_pc, 32'h0);
    reset = 1'b0;

    // streaming, then fill to DEPTH with the core stalled, then drain
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].ready, 1'b0, 32'h0);
      chk_out($sformatf("v%0d", i), tbl[i].req, tbl[i].addr, tbl[i].ivld);
      if (tbl[i].ivld) chk_head($sformatf("v%0d", i), tbl[i].ins, tbl[i].ipc);
    end
    chk("grants_stream", 32'(n_grants), 32'd5);

    // redirect while waiting: queue flushed, stale response dropped
    cyc(1, 0, 32'h0, 0, 0, 32'h0);        chk_out("r1", 1, 32'h14, 0);
    cyc(0, 1, 32'hAAAA0001, 0, 0, 32'h0); chk_out("r2", 0, 32'h18, 0);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);        chk_out("r3", 1, 32'h18, 1); chk_head("r3", 32'hAAAA0001, 32'h14);
    cyc(0, 0, 32'h0, 0, 1, 32'h83);       chk_out("r4", 0, 32'h1C, 1);
    cyc(0, 1, 32'h8D2A0000, 0, 0, 32'h0); chk_out("r5", 0, 32'h80, 0);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);        chk_out("r6", 1, 32'h80, 0);
    cyc(0, 1, 32'h11110000, 0, 0, 32'h0); chk_out("r7", 0, 32'h84, 0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);        chk_out("r8", 1, 32'h84, 1); chk_head("r8", 32'h11110000, 32'h80);

    // no grant: request and address held
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'h0, 0, 0, 32'h0);
      chk_out($sformatf("hold%0d", i), 1, 32'h84, 1);
      chk_head($sformatf("hold%0d", i), 32'h11110000, 32'h80);
    end

    // redirect together with rvalid and a pop
    cyc(1, 0, 32'h0, 0, 0, 32'h0);         chk_out("s1", 1, 32'h84, 1);
    cyc(0, 1, 32'hDEADBEEF, 1, 1, 32'h200); chk_out("s2", 0, 32'h88, 1); chk_head("s2", 32'h11110000, 32'h80);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);         chk_out("s3", 1, 32'h200, 0);
    chk("s3.fetch_pc", fetch_pc, 32'h200);

    // reset while waiting for a response
    cyc(1, 0, 32'h0, 0, 0, 32'h0);        chk_out("t1", 1, 32'h200, 0);
    cyc(0, 1, 32'h00000055, 0, 0, 32'h0); chk_out("t2", 0, 32'h204, 0);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);        chk_out("t3", 1, 32'h204, 1); chk_head("t3", 32'h55, 32'h200);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);        chk_out("t4", 0, 32'h208, 1);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'd8);
    chk("perf_flushes", perf_flushes, 32'd2);
`endif
    reset = 1'b1;
    #1;
    chk_out("t5", 0, 32'h0, 0);
    chk_head("t5", 32'h0, 32'h0);
    chk("t5.fetch_pc", fetch_pc, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_flushes_rst", perf_flushes, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 32'h0, 0, 0, 32'h0);        chk_out("t6", 1, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
